// File: rtl/wb_irq_ctrl.sv
// wb_irq_ctrl: Wishbone interrupt controller with per-source level/edge capture, mask and priority vector.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer in front of the source sampling.
module wb_irq_ctrl #(
  parameter int N_IRQ = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic             wb_we_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  input  logic [N_IRQ-1:0] irq_i,
  output logic             irq_o,
  output logic [4:0]       irq_vec_o
);
  logic [N_IRQ-1:0] src, in_q, in_prev, pending, mask, edge_sel, act, clr, wdat;
  logic [7:0] adr;
  logic [31:0] rdata;
  logic ack, acc, wr_pend, wr_mask, wr_edge;
  logic unused;
  assign unused = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i};
  assign adr = wb_adr_i[7:0];
  assign wdat = wb_dat_i[N_IRQ-1:0];
  assign acc = wb_stb_i & wb_cyc_i & ~ack;
  assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;
  assign wr_pend = acc & wb_we_i & (adr == 8'h04);
  assign wr_mask = acc & wb_we_i & (adr == 8'h08);
  assign wr_edge = acc & wb_we_i & (adr == 8'h0C);
  assign clr = wr_pend ? wdat : '0;
  assign act = pending & mask;
  assign irq_o = |act;
  // Scan downward so the lowest active index is the last one written.
  always_comb begin
    irq_vec_o = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (act[i]) irq_vec_o = 5'(i);
  end
  always_comb begin
    rdata = adr == 8'h00 ? 32'(in_q) :
            adr == 8'h04 ? 32'(pending) :
            adr == 8'h08 ? 32'(mask) :
            adr == 8'h0C ? 32'(edge_sel) :
            adr == 8'h10 ? {irq_o, 26'b0, irq_vec_o} : 32'h0;
  end
`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
    end
  end
  assign src = sync2;
`else
  assign src = irq_i;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      ack      <= 1'b0;
      wb_dat_o <= '0;
      in_q     <= '0;
      in_prev  <= '0;
      pending  <= '0;
      mask     <= '0;
      edge_sel <= '0;
    end else begin
      ack     <= acc;
      in_q    <= src;
      in_prev <= in_q;
      // Edge bits: new rising edge beats a simultaneous W1C; level bits follow in_q.
      pending <= (edge_sel & ((in_q & ~in_prev) | (pending & ~clr))) | (~edge_sel & in_q);
      if (acc) wb_dat_o <= rdata;
      if (wr_mask) mask <= wdat;
      if (wr_edge) edge_sel <= wdat;
    end
  end
endmodule

// File: tb/tb_wb_irq_ctrl.sv
// tb_wb_irq_ctrl: randomized bench for wb_irq_ctrl against a per-source behavioural model.
module tb_wb_irq_ctrl;
  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif
  localparam int LAT = D + 1;
  logic clk = 0, reset = 1, stb = 0, cyc = 0, we = 0;
  logic [31:0] adr = 0, dat_i = 0;
  logic [3:0] sel = 4'hF;
  logic [N-1:0] irq_i = 0;
  logic ack_o, irq_o;
  logic [31:0] dat_o;
  logic [4:0] vec;
  int total = 0, bad = 0;
  bit chk_en = 0;

  wb_irq_ctrl #(.N_IRQ(N)) dut (
    .clk(clk), .reset(reset), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack_o),
    .wb_we_i(we), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .irq_i(irq_i), .irq_o(irq_o), .irq_vec_o(vec)
  );

  always #5 clk = ~clk;

  // Model state: sample history, per-source pending bits and the two config registers.
  bit [N-1:0] hist [3];
  bit [N-1:0] m_inq, m_prev, m_pend, m_mask, m_edge, m_clr, n_mask, n_edge;
  bit m_ack, m_acc;
  bit [31:0] m_dat;

  function automatic bit m_irq();
    return (m_pend & m_mask) != 0;
  endfunction

  function automatic bit [4:0] m_vec();
    bit [N-1:0] a;
    a = m_pend & m_mask;
    for (int i = 0; i < N; i++)
      if (a[i]) return 5'(i);
    return 5'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_inq = '0; m_prev = '0; m_pend = '0; m_mask = '0; m_edge = '0;
      m_ack = 0; m_dat = 0;
    end else begin
      m_clr = '0; n_mask = m_mask; n_edge = m_edge;
      m_acc = stb && cyc && !m_ack;
      if (m_acc) begin
        case (adr[7:0])
          8'h00: m_dat = 32'(m_inq);
          8'h04: m_dat = 32'(m_pend);
          8'h08: m_dat = 32'(m_mask);
          8'h0C: m_dat = 32'(m_edge);
          8'h10: m_dat = {m_irq(), 26'b0, m_vec()};
          default: m_dat = 0;
        endcase
        if (we)
          case (adr[7:0])
            8'h04: m_clr = dat_i[N-1:0];
            8'h08: n_mask = dat_i[N-1:0];
            8'h0C: n_edge = dat_i[N-1:0];
            default: ;
          endcase
      end
      m_ack = m_acc;
      for (int i = 0; i < N; i++)
        if (m_edge[i]) m_pend[i] = (m_inq[i] && !m_prev[i]) || (m_pend[i] && !m_clr[i]);
        else m_pend[i] = m_inq[i];
      m_prev = m_inq;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = irq_i;
      m_inq = hist[D-1];
      m_mask = n_mask; m_edge = n_edge;
    end
  end

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", 32'(ack_o), 32'(stb && cyc && m_ack));
      check("irq", 32'(irq_o), 32'(m_irq()));
      check("vec", 32'(vec), 32'(m_vec()));
      if (stb && cyc && m_ack) check("rdata", dat_o, m_dat);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic bus(input bit w, input logic [7:0] a, input logic [31:0] d, output logic [31:0] r);
    bit got;
    got = 0;
    @(posedge clk);
    #2;
    stb = 1; cyc = 1; we = w; adr = $urandom; adr[7:0] = a; sel = 4'($urandom); dat_i = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #2;
      got = ack_o;
    end
    if (!got) check("ack_timeout", 0, 1);
    r = dat_o;
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1, a, d, r);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r);
    bus(0, a, 0, r);
  endtask

  logic [31:0] r;
  logic [7:0] addrs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 0;
    chk_en = 1;
    rd(8'h00, r); check("rst_status", r, 0);
    rd(8'h04, r); check("rst_pending", r, 0);
    rd(8'h08, r); check("rst_mask", r, 0);
    rd(8'h0C, r); check("rst_edge", r, 0);
    rd(8'h10, r); check("rst_vector", r, 0);
    check("rst_irq", 32'(irq_o), 0);
    // Level source 1
    wr(8'h08, 32'h03); wr(8'h0C, 0);
    irq_i[1] = 1;
    wait_cyc(LAT - 1); check("lvl_rise_early", 32'(irq_o), 0);
    wait_cyc(1); check("lvl_rise", 32'(irq_o), 1);
    rd(8'h10, r); check("lvl_vector", r, 32'h80000001);
    irq_i[1] = 0;
    wait_cyc(LAT - 1); check("lvl_fall_early", 32'(irq_o), 1);
    wait_cyc(1); check("lvl_fall", 32'(irq_o), 0);
    // Edge source 0 with a one-cycle pulse
    wr(8'h0C, 32'h01); wr(8'h08, 32'h01);
    irq_i[0] = 1; wait_cyc(1); irq_i[0] = 0;
    wait_cyc(LAT + 2);
    rd(8'h04, r); check("edge_held", r, 32'h01);
    check("edge_irq", 32'(irq_o), 1);
    wr(8'h04, 32'h01);
    wait_cyc(1); check("w1c_irq", 32'(irq_o), 0);
    // Rising edge coincides with the W1C write: set wins
    irq_i[0] = 1; wait_cyc(D - 1);
    wr(8'h04, 32'h01);
    rd(8'h04, r); check("set_wins", r, 32'h01);
    irq_i[0] = 0;
    // Capture while masked
    wait_cyc(LAT + 2);
    wr(8'h0C, 32'h08); wr(8'h08, 0); wr(8'h04, 32'hFF);
    rd(8'h04, r); check("cleared", r, 0);
    irq_i[3] = 1; wait_cyc(LAT + 1);
    rd(8'h04, r); check("masked_pend", r, 32'h08);
    check("masked_irq", 32'(irq_o), 0);
    wr(8'h08, 32'h08);
    check("unmask_irq", 32'(irq_o), 1);
    check("unmask_vec", 32'(vec), 3);
    // Priority between sources 2 and 5
    wr(8'h0C, 32'h2C);
    irq_i[2] = 1; irq_i[5] = 1; wait_cyc(LAT + 1);
    wr(8'h08, 32'h24);
    check("prio_2", 32'(vec), 2);
    wr(8'h04, 32'h04);
    check("prio_5", 32'(vec), 5);
    rd(8'h10, r); check("prio_vector", r, 32'h80000005);
    // Width clipping and unmapped addresses
    wr(8'h08, 32'hFFFFFFFF); rd(8'h08, r); check("mask_width", r, 32'hFF);
    wr(8'h20, 32'hFFFFFFFF); rd(8'h20, r); check("unmapped", r, 0);
    // Reset during an access
    @(posedge clk); #2 stb = 1; cyc = 1; we = 0; adr = 32'h08;
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 check("rst_mid_ack", 32'(ack_o), 0);
    reset = 0; stb = 0; cyc = 0;
    rd(8'h08, r); check("rst_mid_mask", r, 0);
    // Random traffic
    for (int n = 0; n < 400; n++) begin
      irq_i = N'($urandom);
      if ($urandom_range(0, 2) == 0) wait_cyc($urandom_range(1, 3));
      else bus(1'($urandom), addrs[$urandom_range(0, 7)], $urandom, r);
    end
    wait_cyc(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_irq_ctrl.md
Name: wb_irq_ctrl

Overview:
Wishbone-mapped interrupt controller that consumes the timer block's intr[1:0] and other peripheral interrupt lines.
- Latches each source as level or rising-edge, applies a mask, and drives a single CPU interrupt line.
- Provides a priority-encoded vector of the lowest-numbered active source.
- Sits between the peripherals (timer, ADC, UART) and the soft CPU's interrupt input.

Parameters:
N_IRQ, 8, number of interrupt sources (1..32); bits above N_IRQ-1 in every register read as 0 and ignore writes.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wb_stb_i  in  1  Wishbone strobe
wb_cyc_i  in  1  Wishbone cycle
wb_ack_o  out  1  Wishbone acknowledge
wb_we_i  in  1  Wishbone write enable
wb_adr_i  in  32  byte address; only [7:0] decoded
wb_sel_i  in  4  byte selects; ignored, all accesses are 32-bit
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data (registered)
irq_i  in  N_IRQ  interrupt sources; timer intr[1:0] connects to irq_i[1:0]
irq_o  out  1  CPU interrupt = |(pending & mask)
irq_vec_o  out  5  index of lowest-numbered bit set in pending & mask; 0 when none

Behaviour:
- Register map (wb_adr_i[7:0]):
  - 0x00 STATUS (ro): in_q, the sampled raw sources.
  - 0x04 PENDING (rw1c): pending bits.
  - 0x08 MASK (rw): 1 = enabled.
  - 0x0C EDGE (rw): 1 = rising-edge, 0 = level.
  - 0x10 VECTOR (ro): bit31 = irq_o, [4:0] = irq_vec_o.
  - Other addresses read 0; writes to them are ignored.
- Bus handshake:
  - ack is registered and asserted for exactly one cycle per access.
  - wb_ack_o = stb & cyc & ack.
  - A new access is accepted only when ack = 0, so back-to-back accesses take 2 cycles each.
  - wb_dat_o updates on the ack cycle.
- Sampling:
  - in_q <= irq_i every cycle.
  - in_prev <= in_q every cycle.
- Level mode (EDGE[i] = 0):
  - pending[i] <= in_q[i] every cycle.
  - W1C has no lasting effect while the source stays high.
- Edge mode (EDGE[i] = 1):
  - pending[i] is set when in_q[i] & ~in_prev[i].
  - It is cleared only by writing 1 to PENDING bit i.
  - If set and clear occur in the same cycle, set wins.
- Writing EDGE does not clear pending bits:
  - A bit switched level -> edge keeps its current pending value until W1C.
  - A bit switched edge -> level tracks in_q from the next cycle.
- Masking:
  - MASK does not gate capture; pending bits latch while masked.
  - irq_o and irq_vec_o are combinational from the pending and MASK registers only.
- Latency: irq_i high before edge n -> in_q at edge n -> pending at edge n+1 -> irq_o high after edge n+1 (2 cycles).
- Priority: lowest index wins; irq_vec_o = 0 both when none is active and when source 0 is active. VECTOR bit31 disambiguates the two cases.
- Reset values:
  - in_q, in_prev, pending, MASK, EDGE = 0.
  - ack = 0, wb_dat_o = 0, irq_o = 0, irq_vec_o = 0.
  - Because in_prev resets to 0, a source held high through reset release registers as an edge in edge mode once EDGE is set and a subsequent rising edge occurs. Level-high-at-release is not an edge, since EDGE resets to 0.
- Reset mid-access: ack drops the next cycle and the access is discarded; the master must retry.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_i passes through a 2-flop synchronizer before in_q, for asynchronous sources such as the theremin oscillator domain. Latency becomes 4 cycles. Synchronizer flops reset to 0.
- Undefined: irq_i is sampled directly into in_q; latency is 2 cycles.

Test Plan:
- Reset, then read all five registers -> STATUS/PENDING/MASK/EDGE = 0, VECTOR = 0x00000000, irq_o = 0.
- MASK = 0x03, EDGE = 0; pulse irq_i[1] high for 5 cycles -> irq_o rises 2 cycles after irq_i and falls 2 cycles after irq_i drops; VECTOR reads 0x80000001 while high.
- EDGE = 0x01, MASK = 0x01; 1-cycle pulse on irq_i[0] -> PENDING = 0x01 held, irq_o held. Write PENDING = 0x01 -> irq_o = 0 the cycle after ack.
- Edge source 0: a new rising edge lands in the same cycle as the W1C write -> PENDING bit 0 remains 1.
- MASK = 0; raise irq_i[3] (edge mode) -> PENDING = 0x08, irq_o = 0. Then write MASK = 0x08 -> irq_o = 1, irq_vec_o = 3.
- Sources 2 and 5 pending, both masked in -> irq_vec_o = 2. Clear bit 2 -> irq_vec_o = 5.
